// File: rtl/hdx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdx_pkg
// Description : Shared types and constants for the half-duplex turnaround
//               controller: FSM state encoding and side encoding. The side
//               encoding matches the polarity of the buffer direction bit.
// Revision    : 1.0 - initial release
// ============================================================================
package hdx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2,
        TURN  = 2'd3
    } hdx_state_t;

    // dir = 0 : A drives toward B, dir = 1 : B drives toward A
    localparam logic HDX_SIDE_A = 1'b0;
    localparam logic HDX_SIDE_B = 1'b1;

endpackage : hdx_pkg
`default_nettype wire

// File: rtl/hdx_burst_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hdx_burst_cnt
// Description : Saturating up-counter with synchronous clear. Used for both
//               the turnaround cycle count and the burst length count.
// Ports       : clk, rst (async, active-high)
//               i_clr  - clear to zero (wins over i_inc)
//               i_inc  - increment, holds at all-ones
//               o_cnt  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module hdx_burst_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule : hdx_burst_cnt
`default_nettype wire

// File: rtl/hdx_turnaround_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hdx_turnaround_ctrl
// Description : Half-duplex direction controller. Arbitrates side A / side B
//               requests for a shared bidirectional link, inserts TURN_CYC
//               dead cycles on every direction change and bounds bursts to
//               MAX_BURST cycles while the other side is waiting. dir feeds
//               the buffer ctrl input; a_oe / b_oe gate the side drivers.
// Ports       : clk, rst (async, active-high)
//               a_req, b_req   - side requests
//               a_gnt, b_gnt   - side owns the link this cycle
//               a_oe,  b_oe    - side output enables (mirror the grants)
//               dir            - 0: A drives, 1: B drives
//               busy           - controller not in IDLE
//               turn_count     - TURN entries, wraps   (HDX_STATS_EN only)
//               starve_flag    - sticky starvation flag (HDX_STATS_EN only)
// Config      : define HDX_STATS_EN to add the statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module hdx_turnaround_ctrl
    import hdx_pkg::*;
#(
    parameter int TURN_CYC  = 2,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        b_req,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_oe,
    output logic        b_oe,
    output logic        dir,
`ifdef HDX_STATS_EN
    output logic [15:0] turn_count,
    output logic        starve_flag,
`endif
    output logic        busy
);

    localparam logic [3:0] c_TURN_LAST  = 4'(TURN_CYC - 1);
    localparam logic [7:0] c_BURST_LAST = 8'(MAX_BURST - 1);

    hdx_state_t r_state;
    hdx_state_t w_next;
    logic       w_next_dir;
    logic       r_dir;
    logic       r_last_owner;
    logic       r_a_gnt;
    logic       r_b_gnt;
    logic       r_busy;
    logic       w_target;
    logic       w_in_gnt;
    logic       w_in_turn;
    logic [3:0] w_turn_cnt;
    logic [7:0] w_burst_cnt;

    assign w_in_gnt  = (r_state == GNT_A) || (r_state == GNT_B);
    assign w_in_turn = (r_state == TURN);

    // Counters run only while in their state and clear otherwise, so both
    // read zero on the first cycle of TURN / GNT_x.
    hdx_burst_cnt #(.WIDTH(4)) u_turn_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_in_turn),
        .i_inc (w_in_turn),
        .o_cnt (w_turn_cnt)
    );

    hdx_burst_cnt #(.WIDTH(8)) u_burst_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_in_gnt),
        .i_inc (w_in_gnt),
        .o_cnt (w_burst_cnt)
    );

    // Tie goes to the side that did not own the link last.
    always_comb begin
        w_target = HDX_SIDE_A;
        if (a_req && !b_req) begin
            w_target = HDX_SIDE_A;
        end else if (b_req && !a_req) begin
            w_target = HDX_SIDE_B;
        end else begin
            w_target = ~r_last_owner;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_next_dir = r_dir;
        case (r_state)
            IDLE: begin
                if (a_req || b_req) begin
                    if (w_target == r_dir) begin
                        w_next = (w_target == HDX_SIDE_A) ? GNT_A : GNT_B;
                    end else begin
                        w_next     = TURN;
                        w_next_dir = w_target;
                    end
                end
            end
            GNT_A: begin
                // burst count = cycles already held; this cycle is count+1
                if (!a_req || (b_req && (w_burst_cnt >= c_BURST_LAST))) begin
                    if (b_req) begin
                        w_next     = TURN;
                        w_next_dir = HDX_SIDE_B;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            GNT_B: begin
                if (!b_req || (a_req && (w_burst_cnt >= c_BURST_LAST))) begin
                    if (a_req) begin
                        w_next     = TURN;
                        w_next_dir = HDX_SIDE_A;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            TURN: begin
                // dir already points at the target side
                if (w_turn_cnt >= c_TURN_LAST) begin
                    if ((r_dir == HDX_SIDE_A) ? a_req : b_req) begin
                        w_next = (r_dir == HDX_SIDE_A) ? GNT_A : GNT_B;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_dir        <= HDX_SIDE_A;
            r_last_owner <= HDX_SIDE_B;
            r_a_gnt      <= 1'b0;
            r_b_gnt      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_dir   <= w_next_dir;
            r_a_gnt <= (w_next == GNT_A);
            r_b_gnt <= (w_next == GNT_B);
            r_busy  <= (w_next != IDLE);
            if ((r_state == GNT_A) && (w_next != GNT_A)) begin
                r_last_owner <= HDX_SIDE_A;
            end else if ((r_state == GNT_B) && (w_next != GNT_B)) begin
                r_last_owner <= HDX_SIDE_B;
            end
        end
    end

    assign a_gnt = r_a_gnt;
    assign b_gnt = r_b_gnt;
    assign a_oe  = r_a_gnt;
    assign b_oe  = r_b_gnt;
    assign dir   = r_dir;
    assign busy  = r_busy;

`ifdef HDX_STATS_EN
    localparam logic [9:0] c_STARVE_LIM = 10'(MAX_BURST + TURN_CYC + 2);

    logic [15:0] r_turn_count;
    logic        r_starve;
    logic [9:0]  r_a_wait;
    logic [9:0]  r_b_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_turn_count <= '0;
            r_starve     <= 1'b0;
            r_a_wait     <= '0;
            r_b_wait     <= '0;
        end else begin
            if ((w_next == TURN) && (r_state != TURN)) begin
                r_turn_count <= r_turn_count + 16'd1;
            end
            // wait counters: cycles spent requesting without the grant
            if (a_req && !r_a_gnt) begin
                if (r_a_wait != 10'h3FF) r_a_wait <= r_a_wait + 10'd1;
            end else begin
                r_a_wait <= '0;
            end
            if (b_req && !r_b_gnt) begin
                if (r_b_wait != 10'h3FF) r_b_wait <= r_b_wait + 10'd1;
            end else begin
                r_b_wait <= '0;
            end
            if ((r_a_wait > c_STARVE_LIM) || (r_b_wait > c_STARVE_LIM)) begin
                r_starve <= 1'b1;
            end
        end
    end

    assign turn_count  = r_turn_count;
    assign starve_flag = r_starve;
`endif

endmodule : hdx_turnaround_ctrl
`default_nettype wire

// File: tb/tb_hdx_turnaround_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdx_turnaround_ctrl
// Description : Directed self-checking bench for hdx_turnaround_ctrl with
//               TURN_CYC=2, MAX_BURST=4. Output vector under check is
//               {busy, dir, b_oe, a_oe, b_gnt, a_gnt}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdx_turnaround_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_req = 1'b0;
    logic b_req = 1'b0;
    logic a_gnt, b_gnt, a_oe, b_oe, dir, busy;
`ifdef HDX_STATS_EN
    logic [15:0] turn_count;
    logic        starve_flag;
`endif

    int n_checks = 0;
    int n_err    = 0;

    // {busy, dir, b_oe, a_oe, b_gnt, a_gnt}
    localparam logic [5:0] c_IDLE0 = 6'b000000;
    localparam logic [5:0] c_IDLE1 = 6'b010000;
    localparam logic [5:0] c_GA    = 6'b100101;
    localparam logic [5:0] c_GB    = 6'b111010;
    localparam logic [5:0] c_T0    = 6'b100000;
    localparam logic [5:0] c_T1    = 6'b110000;

    hdx_turnaround_ctrl #(.TURN_CYC(2), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .a_req (a_req),
        .b_req (b_req),
        .a_gnt (a_gnt),
        .b_gnt (b_gnt),
        .a_oe  (a_oe),
        .b_oe  (b_oe),
        .dir   (dir),
`ifdef HDX_STATS_EN
        .turn_count  (turn_count),
        .starve_flag (starve_flag),
`endif
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {busy, dir, b_oe, a_oe, b_gnt, a_gnt};
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic prev_dir;
        #12;
        chk("reset_state", c_IDLE0);
        rst = 1'b0;

        // same-direction grant from IDLE
        a_req = 1'b1;
        tick(); chk("same_dir_gnt_a", c_GA);
        a_req = 1'b0;
        tick(); chk("a_release_idle", c_IDLE0);

        // direction change: B only, dir=0
        b_req = 1'b1;
        tick(); chk("dirchg_turn1", c_T1);
        tick(); chk("dirchg_turn2", c_T1);
        tick(); chk("dirchg_gnt_b", c_GB);

        // burst limit: A raised while B holds
        a_req = 1'b1;
        tick(); chk("burst_b_cyc2", c_GB);
        tick(); chk("burst_b_cyc3", c_GB);
        tick(); chk("burst_b_cyc4", c_GB);
        tick(); chk("burst_b_exit_turn1", c_T0);
        tick(); chk("burst_b_turn2", c_T0);
        tick(); chk("handover_gnt_a", c_GA);
        tick(); chk("burst_a_cyc2", c_GA);
        tick(); chk("burst_a_cyc3", c_GA);
        tick(); chk("burst_a_cyc4", c_GA);
        tick(); chk("burst_a_exit_turn1", c_T1);

        // abandoned turnaround
        a_req = 1'b0;
        b_req = 1'b0;
        tick(); chk("abandon_turn2", c_T1);
        tick(); chk("abandon_idle", c_IDLE1);
        tick(); chk("abandon_stay_idle", c_IDLE1);

        // reset mid-TURN, asynchronously between edges
        a_req = 1'b1;
        tick(); chk("pre_reset_turn", c_T0);
        #2 rst = 1'b1;
        #1 chk("async_reset", c_IDLE0);
        #1 rst = 1'b0;

        // tie after reset: A wins (last owner resets to B)
        b_req = 1'b1;
        tick(); chk("tie_after_reset", c_GA);
        a_req = 1'b0;
        b_req = 1'b0;
        tick(); chk("tie_release_idle", c_IDLE0);

        // tie with last owner A: B wins, through TURN
        a_req = 1'b1;
        b_req = 1'b1;
        tick(); chk("tie_b_turn1", c_T1);
        a_req = 1'b0;
        b_req = 1'b0;
        tick(); chk("tie_b_turn2", c_T1);
        tick(); chk("tie_b_abandon", c_IDLE1);

        // random traffic: mutual exclusion and no OE on a dir change
        prev_dir = dir;
        for (int i = 0; i < 2000; i++) begin
            a_req = 1'($urandom_range(0, 1));
            b_req = 1'($urandom_range(0, 1));
            tick();
            chk_bit("oe_mutex", a_oe & b_oe, 1'b0);
            if (dir !== prev_dir) begin
                chk_bit("oe_on_dir_change", a_oe | b_oe, 1'b0);
            end
            prev_dir = dir;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_hdx_turnaround_ctrl
`default_nettype wire
